// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
// Imported by the slot sub-module and the top level.
package demux_pkg;
   localparam int DEFAULT_WIDTH = 8;
   localparam int NUM_SLOTS     = 4;

   typedef logic [1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// One demux output slot: a data register and a valid flag.
// A load always wins over an ack, so a refill in the ack cycle stays valid.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             ack,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   logic [WIDTH-1:0] data_reg;
   logic             valid_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         data_reg  <= din;
         valid_reg <= 1'b1;
      end else if (ack) begin
         valid_reg <= 1'b0;
      end
   end

   assign dout  = data_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with per-slot valid/ack handshake.
// Back-pressure is per selected slot only; occ tracks the number of full slots.
module demux_1x4_reg
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 s0,
   input  logic                 s1,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out0,
   output logic [WIDTH-1:0]     out1,
   output logic [WIDTH-1:0]     out2,
   output logic [WIDTH-1:0]     out3,
   output logic [NUM_SLOTS-1:0] out_valid,
   input  logic [NUM_SLOTS-1:0] out_ack,
   output logic [2:0]           occ
);

   sel_t                 sel;
   logic                 accept;
   logic [NUM_SLOTS-1:0] load_vec;
   logic [NUM_SLOTS-1:0] valid_vec;
   logic [WIDTH-1:0]     data_arr [NUM_SLOTS];
   logic [2:0]           occ_reg;
   logic [2:0]           occ_next;

   assign sel      = {s1, s0};
   assign in_ready = !valid_vec[sel] | out_ack[sel];
   assign accept   = in_valid & in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign load_vec[gi] = accept && (sel == sel_t'(gi));

         demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_vec[gi]),
            .ack   (out_ack[gi]),
            .din   (in_data),
            .dout  (data_arr[gi]),
            .valid (valid_vec[gi])
         );
      end
   endgenerate

   // Only a fill of an empty slot or an un-refilled ack of a full slot moves the count.
   always_comb begin
      occ_next = occ_reg;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (load_vec[i] && !valid_vec[i])
            occ_next = occ_next + 3'd1;
         else if (!load_vec[i] && out_ack[i] && valid_vec[i])
            occ_next = occ_next - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occ_reg <= 3'd0;
      else
         occ_reg <= occ_next;
   end

   assign out0      = data_arr[0];
   assign out1      = data_arr[1];
   assign out2      = data_arr[2];
   assign out3      = data_arr[3];
   assign out_valid = valid_vec;
   assign occ       = occ_reg;

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Self-checking bench for demux_1x4_reg: directed literal cases plus a
// randomized phase compared every cycle against a slot-array reference model.
module tb_demux_1x4_reg;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       s0;
   logic       s1;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out0;
   logic [7:0] out1;
   logic [7:0] out2;
   logic [7:0] out3;
   logic [3:0] out_valid;
   logic [3:0] out_ack;
   logic [2:0] occ;

   int vectors     = 0;
   int miscompares = 0;

   demux_1x4_reg #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .s0        (s0),
      .s1        (s1),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0      (out0),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .occ       (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: four slots, each with data and a full flag.
   logic [7:0] mdata [4];
   logic [3:0] mvalid;
   wire  [1:0] tsel    = {s1, s0};
   wire        m_ready = !mvalid[tsel] || out_ack[tsel];
   wire        m_acc   = in_valid && m_ready;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 4; n++) mdata[n] <= 8'h00;
         mvalid <= 4'b0000;
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (m_acc && tsel == n[1:0]) begin
               mdata[n]  <= in_data;
               mvalid[n] <= 1'b1;
            end else if (out_ack[n]) begin
               mvalid[n] <= 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_out0", {24'd0, out0}, {24'd0, mdata[0]});
      chk("model_out1", {24'd0, out1}, {24'd0, mdata[1]});
      chk("model_out2", {24'd0, out2}, {24'd0, mdata[2]});
      chk("model_out3", {24'd0, out3}, {24'd0, mdata[3]});
      chk("model_out_valid", {28'd0, out_valid}, {28'd0, mvalid});
      chk("model_occ", {29'd0, occ}, $countones(mvalid));
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, m_ready});
   end

   task automatic set_in(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic [3:0] ack);
      in_valid = v;
      {s1, s0} = sel;
      in_data  = d;
      out_ack  = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic pend;

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, 2'd0, 8'h00, 4'b0000);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {28'd0, out_valid}, 32'h0);
      chk("reset_occ", {29'd0, occ}, 32'h0);
      chk("reset_out0", {24'd0, out0}, 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // First accept lands on the first edge after release.
      set_in(1'b1, 2'b10, 8'hA5, 4'b0000);
      tick();
      chk("first_out2", {24'd0, out2}, 32'hA5);
      chk("first_out_valid", {28'd0, out_valid}, 32'h4);
      chk("first_occ", {29'd0, occ}, 32'd1);

      // Full slot refuses without ack, accepts with ack and stays valid.
      set_in(1'b1, 2'd1, 8'h5A, 4'b0000);
      tick();
      set_in(1'b1, 2'd1, 8'h77, 4'b0000);
      #1 chk("stall_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("stall_out1", {24'd0, out1}, 32'h5A);
      chk("stall_occ", {29'd0, occ}, 32'd2);
      set_in(1'b1, 2'd1, 8'h77, 4'b0010);
      #1 chk("ack_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("refill_out1", {24'd0, out1}, 32'h77);
      chk("refill_valid1", {31'd0, out_valid[1]}, 32'd1);
      chk("refill_occ", {29'd0, occ}, 32'd2);

      set_in(1'b0, 2'd0, 8'h00, 4'b1111);
      tick();
      chk("drain_occ", {29'd0, occ}, 32'd0);

      // Fill all four, then ack all at once.
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, i[1:0], 8'h11 * (i + 1), 4'b0000);
         tick();
         chk("fill_occ", {29'd0, occ}, i + 1);
      end
      set_in(1'b0, 2'd0, 8'h00, 4'b1111);
      tick();
      chk("ackall_occ", {29'd0, occ}, 32'd0);
      chk("ackall_valid", {28'd0, out_valid}, 32'h0);
      chk("retain_out0", {24'd0, out0}, 32'h11);
      chk("retain_out1", {24'd0, out1}, 32'h22);
      chk("retain_out2", {24'd0, out2}, 32'h33);
      chk("retain_out3", {24'd0, out3}, 32'h44);

      // Ack of empty slots is ignored.
      tick();
      chk("empty_ack_occ", {29'd0, occ}, 32'd0);
      chk("empty_ack_out3", {24'd0, out3}, 32'h44);

      // Accept to slot 0 with an ack of slot 3 in the same cycle.
      set_in(1'b1, 2'd3, 8'h99, 4'b0000);
      tick();
      set_in(1'b1, 2'd0, 8'h5C, 4'b1000);
      tick();
      chk("cross_valid", {28'd0, out_valid}, 32'h1);
      chk("cross_occ", {29'd0, occ}, 32'd1);
      chk("cross_out0", {24'd0, out0}, 32'h5C);

      // Build occ=3, then reset asynchronously mid-cycle.
      set_in(1'b1, 2'd1, 8'hB1, 4'b0000);
      tick();
      set_in(1'b1, 2'd2, 8'hB2, 4'b0000);
      tick();
      chk("pre_reset_occ", {29'd0, occ}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_occ", {29'd0, occ}, 32'd0);
      chk("async_valid", {28'd0, out_valid}, 32'h0);
      chk("async_out2", {24'd0, out2}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      set_in(1'b1, 2'd2, 8'hC3, 4'b0000);
      #1 chk("post_reset_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("post_reset_out2", {24'd0, out2}, 32'hC3);

      // Randomized phase; a refused offer is held stable until accepted.
      for (int k = 0; k < 600; k++) begin
         pend = in_valid && !m_ready;
         if (pend) begin
            for (int n = 0; n < 4; n++) out_ack[n] = ($urandom_range(0, 3) == 0);
         end else begin
            in_valid = ($urandom_range(0, 2) != 0);
            {s1, s0} = 2'($urandom_range(0, 3));
            in_data  = 8'($urandom);
            for (int n = 0; n < 4; n++) out_ack[n] = ($urandom_range(0, 3) == 0);
         end
         tick();
         if ($urandom_range(0, 99) == 0) begin
            #2 rst_n = 1'b0;
            #1 chk("rand_async_occ", {29'd0, occ}, 32'd0);
            @(negedge clk) rst_n = 1'b1;
            in_valid = 1'b0;
         end
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
